// File: rtl/bird_motion_scheduler_if.sv
// Key/collision inputs and fly/gravity/round-state outputs of the bird motion scheduler.
// master is the scheduler side; slave is the surrounding game logic.
interface bird_motion_scheduler_if;
  logic key;
  logic bird_out;
  logic collision;
  logic fly;
  logic gravity;
  logic game_over;
  logic playing;

  modport master (
    input  key, bird_out, collision,
    output fly, gravity, game_over, playing
  );

  modport slave (
    output key, bird_out, collision,
    input  fly, gravity, game_over, playing
  );
endinterface

// File: rtl/bird_motion_scheduler.sv
// Turns key presses into timed multi-step flaps, issues periodic gravity steps and tracks round state.
// All outputs registered: a key edge sampled at edge k yields fly in the cycle after k; no backpressure.
module bird_motion_scheduler #(
  parameter int GRAV_PERIOD = 8,
  parameter int FLY_STEPS   = 3,
  parameter int FLY_GAP     = 2,
  parameter int CNT_W       = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  bird_motion_scheduler_if.master  bus
);

  localparam logic [CNT_W-1:0] GRAV_LAST  = CNT_W'(GRAV_PERIOD - 1);
  localparam logic [CNT_W-1:0] STEPS_INIT = CNT_W'(FLY_STEPS - 1);
  localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'(FLY_GAP - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PLAY, FLAP, OVER} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] grav_t, grav_nxt;
  logic [CNT_W-1:0] steps_left, steps_nxt;
  logic [CNT_W-1:0] gap, gap_nxt;
  logic             fly_nxt, gravity_nxt;
  logic             key_q;
  logic             key_edge;
  logic             hit;

  assign key_edge = bus.key & ~key_q;
  assign hit      = bus.bird_out | bus.collision;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grav_t        <= '0;
      steps_left    <= '0;
      gap           <= '0;
      // Held high so a key already down at reset release is not seen as a press.
      key_q         <= 1'b1;
      bus.fly       <= 1'b0;
      bus.gravity   <= 1'b0;
      bus.game_over <= 1'b0;
      bus.playing   <= 1'b0;
    end else begin
      state         <= state_nxt;
      grav_t        <= grav_nxt;
      steps_left    <= steps_nxt;
      gap           <= gap_nxt;
      key_q         <= bus.key;
      bus.fly       <= fly_nxt;
      bus.gravity   <= gravity_nxt;
      bus.game_over <= (state_nxt == OVER);
      bus.playing   <= (state_nxt == PLAY) || (state_nxt == FLAP);
    end
  end

  always_comb begin
    state_nxt   = state;
    grav_nxt    = grav_t;
    steps_nxt   = steps_left;
    gap_nxt     = gap;
    fly_nxt     = 1'b0;
    gravity_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (key_edge) begin
          state_nxt = FLAP;
          fly_nxt   = 1'b1;
          steps_nxt = STEPS_INIT;
          gap_nxt   = GAP_INIT;
        end
      end

      PLAY: begin
        if (hit) begin
          state_nxt = OVER;
        end else if (key_edge) begin
          state_nxt = FLAP;
          fly_nxt   = 1'b1;
          steps_nxt = STEPS_INIT;
          gap_nxt   = GAP_INIT;
        end else if (grav_t == GRAV_LAST) begin
          gravity_nxt = 1'b1;
          grav_nxt    = '0;
        end else begin
          grav_nxt = grav_t + ONE;
        end
      end

      FLAP: begin
        if (hit) begin
          state_nxt = OVER;
        end else if (key_edge) begin
          // Re-press extends the flap without an extra pulse on this edge.
          steps_nxt = STEPS_INIT;
          gap_nxt   = GAP_INIT;
        end else if (gap != '0) begin
          gap_nxt = gap - ONE;
        end else if (steps_left != '0) begin
          fly_nxt   = 1'b1;
          steps_nxt = steps_left - ONE;
          gap_nxt   = GAP_INIT;
        end else begin
          state_nxt = PLAY;
          grav_nxt  = '0;
        end
      end

      OVER: begin
        if (key_edge) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bird_motion_scheduler.sv
// Randomised and scenario-driven bench; expected outputs come from an absolute-time schedule model.
module tb_bird_motion_scheduler;

  localparam int P = 8;
  localparam int S = 3;
  localparam int G = 2;

  localparam int M_IDLE = 0;
  localparam int M_FLAP = 1;
  localparam int M_PLAY = 2;
  localparam int M_OVER = 3;

  logic clock;
  logic reset;

  bird_motion_scheduler_if bus ();

  bird_motion_scheduler #(
    .GRAV_PERIOD (P),
    .FLY_STEPS   (S),
    .FLY_GAP     (G),
    .CNT_W       (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  // Model state: flap start time and the edge at which gliding begins, in absolute edge counts.
  int mode;
  int n;
  int t0;
  int play_at;
  bit m_kq;
  bit e_fly, e_grav;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    mode  = M_IDLE;
    m_kq  = 1'b1;
    e_fly = 1'b0;
    e_grav = 1'b0;
    t0 = 0;
    play_at = 0;
  endtask

  task automatic model_edge();
    bit ke;
    ke = bus.key && !m_kq;
    e_fly = 1'b0;
    e_grav = 1'b0;
    case (mode)
      M_IDLE: if (ke) begin
        mode = M_FLAP; t0 = n; play_at = n + S * G; e_fly = 1'b1;
      end
      M_FLAP, M_PLAY: begin
        if (bus.bird_out || bus.collision) begin
          mode = M_OVER;
        end else if (ke) begin
          if (mode == M_PLAY) e_fly = 1'b1;
          mode = M_FLAP; t0 = n; play_at = n + S * G;
        end else if (mode == M_FLAP) begin
          if (n == play_at) mode = M_PLAY;
          else if ((n - t0) % G == 0) e_fly = 1'b1;
        end else if (n > play_at && (n - play_at) % P == 0) begin
          e_grav = 1'b1;
        end
      end
      default: if (ke) mode = M_IDLE;
    endcase
    m_kq = bus.key;
    n++;
  endtask

  function automatic bit grav_due_next();
    return (mode == M_PLAY) && (n > play_at) && ((n - play_at) % P == 0);
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("fly",       32'(bus.fly),       32'(e_fly));
    check("gravity",   32'(bus.gravity),   32'(e_grav));
    check("game_over", 32'(bus.game_over), 32'(mode == M_OVER));
    check("playing",   32'(bus.playing),   32'(mode == M_FLAP || mode == M_PLAY));
    check("fly_grav_excl", 32'(bus.fly & bus.gravity), 32'd0);
  endtask

  task automatic steps(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fly"},       32'(bus.fly),       32'd0);
    check({tag, "_gravity"},   32'(bus.gravity),   32'd0);
    check({tag, "_game_over"}, 32'(bus.game_over), 32'd0);
    check({tag, "_playing"},   32'(bus.playing),   32'd0);
  endtask

  // Asserts reset between clock edges and checks the outputs clear without waiting for an edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_all_zero(tag);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press();
    bus.key = 1'b0;
    step();
    bus.key = 1'b1;
    step();
  endtask

  initial begin
    bit found;
    n = 0;
    model_reset();
    reset = 1'b1;
    bus.key = 1'b1;
    bus.bird_out = 1'b0;
    bus.collision = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;

    // Key held through reset release must not start a round.
    steps(5);

    // Start flap, then glide through three gravity steps.
    press();
    steps(34);

    // Re-press inside a flap, landing on an edge where a fly pulse is due.
    press();
    bus.key = 1'b0;
    step();
    bus.key = 1'b1;
    step();
    steps(20);

    // Collision on the edge where gravity is due.
    found = 1'b0;
    for (int i = 0; i < 3 * P && !found; i++) begin
      if (grav_due_next()) found = 1'b1;
      else step();
    end
    check("grav_search", 32'(found), 32'd1);
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    check("hit_no_gravity", 32'(bus.gravity), 32'd0);
    check("hit_game_over", 32'(bus.game_over), 32'd1);

    // OVER ignores bird_out; key returns to IDLE, next key starts a flap.
    for (int i = 0; i < 6; i++) begin
      bus.bird_out = ~bus.bird_out;
      step();
    end
    bus.bird_out = 1'b0;
    press();
    steps(3);
    press();
    steps(2);

    async_reset("mid_flap");
    steps(4);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) bus.key = ~bus.key;
      bus.collision = ($urandom_range(59) == 0);
      bus.bird_out  = ($urandom_range(79) == 0);
      if ($urandom_range(499) == 0) async_reset("rand_reset");
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
